// File: rtl/uart_pkg.sv
// Shared definitions for the UART IO blocks: register offsets, status bit
// positions and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [1:0] STATUS_OFF = 2'b00;
    localparam logic [1:0] TXDATA_OFF = 2'b10;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_TX_BUSY  = 1;
    localparam int STAT_OVERFLOW = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Keeps the baud counter at least one bit wide for very fast baud rates.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push is ignored when full and pop
// is ignored when empty, and the head entry is presented combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores fill a byte FIFO, an 8N1 FSM
// drains it onto serial_out, and a STATUS register supports polling.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic        io_sel,
    input  logic [3:0]  io_we,
    input  logic        io_re,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    output logic        serial_out
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W          = cnt_width(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

    logic [1:0]       reg_off;
    logic             wr_en;
    logic             rd_en;
    logic             tx_wr;
    logic             stat_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             load_frame;
    logic             overflow;
    logic             tx_ready;
    logic             tx_busy;
    logic [31:0]      status_word;
    logic             unused_bits;

    tx_state_e        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    assign reg_off     = io_addr[3:2];
    assign wr_en       = io_sel && (|io_we);
    assign rd_en       = io_sel && io_re;
    assign tx_wr       = wr_en && (reg_off == TXDATA_OFF);
    assign stat_wr     = wr_en && (reg_off == STATUS_OFF);
    assign unused_bits = ^{io_addr[31:4], io_addr[1:0], io_din[31:8]};

    // A new frame starts from IDLE, or straight out of the last STOP cycle so
    // queued bytes follow each other without an idle bit time.
    assign load_frame = !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && (baud_cnt == CNT_LAST)));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr && !fifo_full),
        .din   (io_din[7:0]),
        .pop   (load_frame),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state != IDLE) || !fifo_empty;

    always_comb begin
        status_word                = '0;
        status_word[STAT_TX_READY] = tx_ready;
        status_word[STAT_TX_BUSY]  = tx_busy;
        status_word[STAT_OVERFLOW] = overflow;
    end

    // fifo_full is the registered start-of-cycle value, so a store that meets
    // a same-cycle pop while full is still dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (tx_wr && fifo_full) begin
            overflow <= 1'b1;
        end else if (stat_wr && io_din[STAT_OVERFLOW]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_dout <= '0;
        end else if (rd_en) begin
            io_dout <= (reg_off == STATUS_OFF) ? status_word : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (load_frame) begin
                        shift      <= fifo_dout;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= START;
                        serial_out <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= DATA;
                        serial_out <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state      <= STOP;
                            serial_out <= 1'b1;
                        end else begin
                            shift      <= shift >> 1;
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (load_frame) begin
                            shift      <= fifo_dout;
                            bit_idx    <= '0;
                            state      <= START;
                            serial_out <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at 10 clocks per bit: directed bus traffic, with a
// frame decoder and a read-data monitor checking against expected queues.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_addr = '0;
  logic        io_sel = 1'b0;
  logic [3:0]  io_we = '0;
  logic        io_re = 1'b0;
  logic [31:0] io_din = '0;
  logic [31:0] io_dout;
  logic        serial_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Frame expectations: {start edge number, data byte}.
  logic [39:0] exp_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];

  uart_tx_mmio #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_addr    (io_addr),
    .io_sel     (io_sel),
    .io_we      (io_we),
    .io_re      (io_re),
    .io_din     (io_din),
    .io_dout    (io_dout),
    .serial_out (serial_out)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- frame monitor ----------------
  logic       mon_active = 1'b0;
  int         mon_s = 0;
  int         mon_pos = 0;
  logic [7:0] mon_data = '0;
  logic [39:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (serial_out == 1'b0) begin
        mon_active = 1'b1;
        mon_s = cyc;
      end
    end else begin
      mon_pos = cyc - mon_s;
      if (mon_pos == 5) check("start_bit", 32'(serial_out), 32'd0);
      if (mon_pos >= 15 && mon_pos <= 85 && ((mon_pos - 15) % 10) == 0)
        mon_data[3'((mon_pos - 15) / 10)] = serial_out;
      if (mon_pos == 95) begin
        check("stop_bit", 32'(serial_out), 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got byte 0x%0h at edge %0d expected no frame", mon_data, mon_s);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_byte", 32'(mon_data), 32'(mon_e[7:0]));
          check("frame_start_edge", 32'(mon_s), mon_e[39:8]);
        end
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- read-data monitor ----------------
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= io_sel && io_re;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", io_dout);
      end else begin
        check(rd_name_q.pop_front(), io_dout, rd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] we, output int edge_n);
    io_sel  = 1'b1;
    io_we   = we;
    io_addr = addr;
    io_din  = data;
    edge_n  = cyc + 1;
    @(negedge clk);
    io_sel = 1'b0;
    io_we  = '0;
    io_din = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    io_sel  = 1'b1;
    io_re   = 1'b1;
    io_addr = addr;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(negedge clk);
    io_sel = 1'b0;
    io_re  = 1'b0;
  endtask

  // Returns at the negedge just before edge e.
  task automatic wait_until(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_frames", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] ovf_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int n, m, m2, p0, pe, r, t, tmp;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_serial_out", 32'(serial_out), 32'd1);
    check("reset_io_dout", io_dout, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Status polling and unmapped offsets
    bus_read(32'h0, 32'h1, "status_idle");
    bus_read(32'h4, 32'h0, "read_off01");
    bus_read(32'hC, 32'h0, "read_off11");
    bus_read(32'h8, 32'h0, "read_txdata");
    bus_write(32'h4, 32'hFFFF_FFFF, 4'hf, tmp);
    bus_write(32'hC, 32'hFFFF_FFFF, 4'hf, tmp);
    bus_read(32'h0, 32'h1, "status_after_ignored_writes");

    // Single byte via a byte-lane store
    bus_write(32'h8, 32'hDEAD_BEA5, 4'b0001, n);
    exp_q.push_back({32'(n + 1), 8'hA5});
    wait_until(n + 101);
    bus_read(32'h0, 32'h3, "status_busy_in_stop");
    bus_read(32'h0, 32'h1, "status_idle_after_frame");
    drain(300);
    repeat (5) @(negedge clk);

    // Back-to-back frames
    bus_write(32'h8, 32'h00, 4'hf, m);
    bus_write(32'h8, 32'hFF, 4'hf, m2);
    exp_q.push_back({32'(m + 1), 8'h00});
    exp_q.push_back({32'(m + 101), 8'hFF});
    drain(400);
    repeat (5) @(negedge clk);

    // Overflow, clear, and full-boundary store on the pop edge
    p0 = 0;
    for (int i = 0; i < 6; i++) begin
      bus_write(32'h8, 32'(ovf_bytes[i]), 4'hf, pe);
      if (i == 0) p0 = pe;
    end
    for (int i = 0; i < 5; i++) exp_q.push_back({32'(p0 + 1 + 100 * i), ovf_bytes[i]});
    bus_read(32'h0, 32'h6, "status_overflow");
    bus_write(32'h0, 32'h4, 4'hf, tmp);
    bus_read(32'h0, 32'h2, "status_ovf_cleared_full");
    wait_until(p0 + 100);
    bus_read(32'h0, 32'h2, "status_full_before_pop");
    bus_write(32'h8, 32'h77, 4'hf, tmp);
    bus_read(32'h0, 32'h7, "status_boundary_drop");
    drain(700);
    wait_until(p0 + 502);
    bus_read(32'h0, 32'h5, "status_sticky_ovf_idle");
    bus_write(32'h0, 32'h4, 4'hf, tmp);
    bus_read(32'h0, 32'h1, "status_ovf_clear_idle");

    // Reset during data bit 3 with more bytes queued
    bus_write(32'h8, 32'h96, 4'hf, r);
    bus_write(32'h8, 32'h5A, 4'hf, tmp);
    bus_write(32'h8, 32'h5B, 4'hf, tmp);
    wait_until(r + 45);
    check("pre_reset_data_bit3", 32'(serial_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_serial_out", 32'(serial_out), 32'd1);
    check("midframe_reset_io_dout", io_dout, 32'd0);
    rst = 1'b0;
    bus_read(32'h0, 32'h1, "status_after_reset");
    bus_write(32'h8, 32'h3C, 4'hf, t);
    exp_q.push_back({32'(t + 1), 8'h3C});
    drain(300);
    repeat (120) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    tests++;
    fails++;
    $display("FAIL watchdog: got edge %0d expected completion before 20000", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
